// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// with a valid/ready handshake and a single global advance across all stages.
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;

    if ((WIDTH % BLK) != 0 || NBLK < 1) begin : g_bad_width
        $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLK");
    end

    // Flat storage offsets: stage k keeps k+1 resolved sum blocks and the operand
    // bits above its own block, so no register bit is ever dead.
    function automatic int op_off(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += WIDTH - (j + 1) * BLK;
        return s;
    endfunction

    function automatic int sm_off(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += (j + 1) * BLK;
        return s;
    endfunction

    // Ripple one block; returns {carry_out, carry_into_block_msb, sum}.
    function automatic logic [BLK+1:0] blk_add(input logic [BLK-1:0] x,
                                               input logic [BLK-1:0] y,
                                               input logic c);
        logic [BLK-1:0] s;
        logic           cc;
        logic           cm;
        s  = '0;
        cc = c;
        cm = c;
        for (int i = 0; i < BLK; i++) begin
            cm   = cc;
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {cc, cm, s};
    endfunction

    localparam int OPT = op_off(NBLK);
    localparam int OPW = (OPT > 0) ? OPT : 1;
    localparam int SMW = sm_off(NBLK);

    logic [OPW-1:0]  aops_r, bops_r, aops_nx_s, bops_nx_s;
    logic [SMW-1:0]  sum_r, sum_nx_s;
    logic [NBLK-1:0] valid_r, carry_r, valid_nx_s, carry_nx_s;
    logic            ovf_r, ovf_nx_s;
    logic [WIDTH-1:0] b_eff_s;
    logic            c0_s;
    logic            adv_s;

    assign b_eff_s = sub ? ~b : b;
    assign c0_s    = sub ? ~cin : cin;
    assign adv_s   = !valid_r[NBLK-1] || out_ready;

    genvar k;
    for (k = 0; k < NBLK; k++) begin : g_stg
        localparam int RIN = WIDTH - k * BLK;
        logic [RIN-1:0] a_in_s, b_in_s;
        logic           c_in_s, v_in_s;
        logic [BLK+1:0] r0_s, r1_s, sel_s;

        if (k == 0) begin : g_in
            assign a_in_s = a;
            assign b_in_s = b_eff_s;
            assign c_in_s = c0_s;
            assign v_in_s = in_valid;
            assign sum_nx_s[sm_off(0) +: BLK] = sel_s[BLK-1:0];
        end else begin : g_in
            assign a_in_s = aops_r[op_off(k-1) +: RIN];
            assign b_in_s = bops_r[op_off(k-1) +: RIN];
            assign c_in_s = carry_r[k-1];
            assign v_in_s = valid_r[k-1];
            assign sum_nx_s[sm_off(k) +: (k+1)*BLK] =
                {sel_s[BLK-1:0], sum_r[sm_off(k-1) +: k*BLK]};
        end

        if (k < NBLK - 1) begin : g_fwd
            assign aops_nx_s[op_off(k) +: RIN-BLK] = a_in_s[RIN-1:BLK];
            assign bops_nx_s[op_off(k) +: RIN-BLK] = b_in_s[RIN-1:BLK];
        end

        assign r0_s  = blk_add(a_in_s[BLK-1:0], b_in_s[BLK-1:0], 1'b0);
        assign r1_s  = blk_add(a_in_s[BLK-1:0], b_in_s[BLK-1:0], 1'b1);
        assign sel_s = c_in_s ? r1_s : r0_s;
        assign carry_nx_s[k] = sel_s[BLK+1];
        assign valid_nx_s[k] = v_in_s;

        if (k == NBLK - 1) begin : g_last
            assign ovf_nx_s = sel_s[BLK+1] ^ sel_s[BLK];
        end
    end

    if (NBLK == 1) begin : g_noops
        assign aops_nx_s = '0;
        assign bops_nx_s = '0;
    end

    // Whole pipeline shifts together on advance and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            carry_r <= '0;
            sum_r   <= '0;
            aops_r  <= '0;
            bops_r  <= '0;
            ovf_r   <= 1'b0;
        end else if (adv_s) begin
            valid_r <= valid_nx_s;
            carry_r <= carry_nx_s;
            sum_r   <= sum_nx_s;
            aops_r  <= aops_nx_s;
            bops_r  <= bops_nx_s;
            ovf_r   <= ovf_nx_s;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = valid_r[NBLK-1];
    assign sum       = sum_r[sm_off(NBLK-1) +: WIDTH];
    assign cout      = carry_r[NBLK-1];
    assign ovf       = ovf_r;

endmodule
